rbm_core_bwd: RTL and testbench

RBM_CORE_BWD -- requirements
Module: rbm_core_bwd

---
 rtl/rbm_pkg.sv | 50 +++++
 rtl/rbm_core_bwd_if.sv | 32 +++
 rtl/sigmoid_lut.sv | 45 ++++
 rtl/rbm_core_bwd.sv | 116 +++++++++++
 tb/tb_rbm_core_bwd.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/rbm_pkg.sv
// Shared fixed-point widths, FSM state type and arithmetic helpers for the
// RBM backward (visible reconstruction) datapath.
package rbm_pkg;

  localparam int Q1_7_W    = 8;
  localparam int Q1_15_W   = 16;
  localparam int Q0_16_W   = 16;
  localparam int ACC_W     = 32;
  localparam int SIG_SHIFT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_ACC,
    S_ACT,
    S_OUT
  } rbm_bwd_state_t;

  // Unsigned Q0.16 probability times signed Q1.15 weight, back to Q16.15 scale.
  function automatic logic signed [ACC_W-1:0] mul_term(
    input logic        [Q0_16_W-1:0] h,
    input logic signed [Q1_15_W-1:0] w
  );
    logic signed [32:0] prod;
    logic signed [32:0] shifted;
    prod    = $signed(33'(h)) * 33'(w);
    shifted = prod >>> 16;
    return shifted[ACC_W-1:0];
  endfunction

  // Clamps instead of wrapping so an extreme bias cannot flip the sign.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = (ACC_W + 1)'(a) + (ACC_W + 1)'(b);
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [15:0] sig_in(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> SIG_SHIFT;
    if (sh > 32'sd32767)  return 16'h7FFF;
    if (sh < -32'sd32768) return 16'h8000;
    return sh[15:0];
  endfunction

endpackage

// File: rtl/rbm_core_bwd_if.sv
// Control, memory-read and output-stream signals of the backward core.
interface rbm_core_bwd_if #(
  parameter int V_DIM = 256,
  parameter int H_DIM = 64
);
  localparam int W_AW = $clog2(V_DIM * H_DIM);
  localparam int A_AW = $clog2(V_DIM);

  logic                   start;
  logic                   busy;
  logic                   done;
  logic [15:0]            h_mem [H_DIM];
  logic [W_AW-1:0]        w_addr;
  logic signed [15:0]     w_rdata;
  logic [A_AW-1:0]        a_addr;
  logic signed [31:0]     a_rdata;
  logic                   p_valid;
  logic                   p_ready;
  logic [15:0]            p_data;
  logic [A_AW-1:0]        p_idx;
  logic                   p_last;

  modport slave (
    input  start, h_mem, w_rdata, a_rdata, p_ready,
    output busy, done, w_addr, a_addr, p_valid, p_data, p_idx, p_last
  );

  modport master (
    output start, h_mem, w_rdata, a_rdata, p_ready,
    input  busy, done, w_addr, a_addr, p_valid, p_data, p_idx, p_last
  );
endinterface

// File: rtl/sigmoid_lut.sv
// Sigmoid of a Q4.11 input as Q0.16: linear interpolation between exact
// values at integer points 0..8, mirrored for negative inputs; 1-cycle latency.
module sigmoid_lut (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] x_i,
  output logic [15:0] y_o
);

  function automatic logic [15:0] knot(input logic [3:0] n);
    case (n)
      4'd0:    return 16'd32768;
      4'd1:    return 16'd47910;
      4'd2:    return 16'd57724;
      4'd3:    return 16'd62428;
      4'd4:    return 16'd64358;
      4'd5:    return 16'd65097;
      4'd6:    return 16'd65374;
      4'd7:    return 16'd65476;
      default: return 16'd65514;
    endcase
  endfunction

  logic [16:0] mag;
  logic [15:0] lo, hi, y_pos, y_d;
  logic [26:0] slope;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    mag   = x_i[15] ? (17'd0 - {x_i[15], x_i}) : {1'b0, x_i};
    lo    = knot(4'(mag[14:11]));
    hi    = knot(4'(mag[14:11]) + 4'd1);
    slope = 27'(hi - lo) * 27'(mag[10:0]);
    y_pos = lo + 16'(slope >> 11);
    if (mag[16:11] >= 6'd8) y_pos = knot(4'd8);
    y_d   = x_i[15] ? 16'(17'h1_0000 - {1'b0, y_pos}) : y_pos;
  end

  always_ff @(posedge clk) begin
    if (rst)       y_o <= '0;
    else if (en_i) y_o <= y_d;
  end

endmodule

// File: rtl/rbm_core_bwd.sv
// RBM backward pass: for each visible unit i, p_i = sigmoid(a_i + sum_j h_j*W_ij),
// streamed out through a valid/ready handshake.
module rbm_core_bwd
  import rbm_pkg::*;
#(
  parameter int V_DIM = 256,
  parameter int H_DIM = 64
) (
  input logic           clk,
  input logic           rst,
  rbm_core_bwd_if.slave bus
);

  localparam int W_AW = $clog2(V_DIM * H_DIM);
  localparam int A_AW = $clog2(V_DIM);
  localparam int K_W  = (H_DIM > 1) ? $clog2(H_DIM) : 1;
  localparam logic [A_AW-1:0] I_LAST = A_AW'(V_DIM - 1);
  localparam logic [K_W-1:0]  K_LAST = K_W'(H_DIM - 1);

  rbm_bwd_state_t         state_q;
  logic [A_AW-1:0]        i_q;
  logic [K_W-1:0]         k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [W_AW-1:0]        w_addr_q;
  logic [A_AW-1:0]        a_addr_q;
  logic [A_AW-1:0]        p_idx_q;
  logic                   busy_q, done_q, p_valid_q, p_last_q;

  logic signed [ACC_W-1:0] term_d;
  logic [15:0]             sig_x_d;

  assign term_d  = mul_term(bus.h_mem[k_q], bus.w_rdata);
  assign sig_x_d = sig_in(acc_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      w_addr_q  <= '0;
      a_addr_q  <= '0;
      p_idx_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          i_q      <= '0;
          a_addr_q <= '0;
          w_addr_q <= '0;
          busy_q   <= 1'b1;
          state_q  <= S_BIAS;
        end
        S_BIAS: begin
          k_q     <= '0;
          if (H_DIM > 1) w_addr_q <= w_addr_q + 1'b1;
          state_q <= S_ACC;
        end
        S_ACC: begin
          // Bias and weight 0 both arrive in the first ACC cycle.
          acc_q <= sat_add((k_q == '0) ? bus.a_rdata : acc_q, term_d);
          if (k_q == K_LAST) begin
            state_q <= S_ACT;
          end else begin
            k_q <= k_q + 1'b1;
            if (int'(k_q) < H_DIM - 2) w_addr_q <= w_addr_q + 1'b1;
          end
        end
        S_ACT: begin
          p_valid_q <= 1'b1;
          p_idx_q   <= i_q;
          p_last_q  <= (i_q == I_LAST);
          state_q   <= S_OUT;
        end
        S_OUT: if (bus.p_ready) begin
          p_valid_q <= 1'b0;
          p_last_q  <= 1'b0;
          if (i_q == I_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            // w_addr sits on row i's last weight, so +1 is row i+1's first.
            i_q      <= i_q + 1'b1;
            a_addr_q <= i_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
            state_q  <= S_BIAS;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sigmoid_lut u_sigmoid (
    .clk  (clk),
    .rst  (rst),
    .en_i (state_q == S_ACT),
    .x_i  (sig_x_d),
    .y_o  (bus.p_data)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.w_addr  = w_addr_q;
  assign bus.a_addr  = a_addr_q;
  assign bus.p_valid = p_valid_q;
  assign bus.p_idx   = p_idx_q;
  assign bus.p_last  = p_last_q;

endmodule

// File: tb/tb_rbm_core_bwd.sv
// Directed bench for rbm_core_bwd at V_DIM=4, H_DIM=4 with hand-computed
// reconstruction probabilities and cycle-exact latency checks.
module tb_rbm_core_bwd;

  localparam int V  = 4;
  localparam int H  = 4;
  localparam int WA = $clog2(V * H);
  localparam int AA = $clog2(V);

  logic clk = 1'b0;
  logic rst;

  rbm_core_bwd_if #(.V_DIM(V), .H_DIM(H)) bus ();

  rbm_core_bwd #(.V_DIM(V), .H_DIM(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [15:0] w_mem [V*H];
  logic signed [31:0] a_mem [V];
  logic [15:0]        exp_p [V];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read weight and bias memories.
  always @(posedge clk) begin
    bus.w_rdata <= w_mem[bus.w_addr];
    bus.a_rdata <= a_mem[bus.a_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] h, input logic signed [15:0] w, input logic signed [31:0] a);
    for (int k = 0; k < H; k++) bus.h_mem[k] = h;
    for (int n = 0; n < V*H; n++) w_mem[n] = w;
    for (int i = 0; i < V; i++) a_mem[i] = a;
  endtask

  // One full run; hold > 0 stalls p_ready for that many cycles at idx 0.
  task automatic run(input bit check_lat, input bit repulse, input int hold);
    int cyc, last, t;
    bus.p_ready = (hold == 0);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc  = 1;
    last = 0;
    for (int idx = 0; idx < V; idx++) begin
      t = 0;
      while (!bus.p_valid && t < 100) begin
        bus.start = repulse && (cyc == 3);
        @(negedge clk);
        cyc++;
        t++;
      end
      bus.start = 1'b0;
      check($sformatf("p_valid_%0d", idx), bus.p_valid, 1);
      if (check_lat) check($sformatf("latency_%0d", idx), cyc - last, H + 3);
      last = cyc;
      check($sformatf("p_data_%0d", idx), bus.p_data, exp_p[idx]);
      check($sformatf("p_idx_%0d", idx), bus.p_idx, idx);
      check($sformatf("p_last_%0d", idx), bus.p_last, idx == V - 1);
      if (idx == 0 && hold > 0) begin
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          cyc++;
          check($sformatf("hold_stable_%0d", c),
                {bus.p_valid, bus.p_data, bus.p_idx, bus.w_addr, bus.a_addr},
                {1'b1, exp_p[0], AA'(0), WA'(H - 1), AA'(0)});
        end
        bus.p_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_pulse", {bus.done, bus.busy}, 2'b10);
    @(negedge clk);
    check("done_single_cycle", bus.done, 0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.p_ready = 1'b1;
    fill(16'h0000, 16'sh0000, 32'sh0);
    repeat (2) @(negedge clk);
    check("reset_state",
          {bus.busy, bus.done, bus.p_valid, bus.p_last, bus.p_data, bus.p_idx, bus.w_addr, bus.a_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {bus.busy, bus.p_valid, bus.p_data}, 0);

    // h = 0, zero bias: sigmoid(0) everywhere; start re-pulsed mid-run.
    for (int n = 0; n < V*H; n++) w_mem[n] = 16'sh1234 + 16'(n);
    exp_p = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run(1'b1, 1'b1, 0);

    // term 16383 per hidden unit, acc 65532, x 4095.
    fill(16'hFFFF, 16'sh4000, 32'sh0);
    exp_p = '{16'hE177, 16'hE177, 16'hE177, 16'hE177};
    run(1'b1, 1'b0, 0);

    // Bias only, distinct per visible unit: x = 0, -4096, 4096, 1024.
    fill(16'h0000, 16'sh7FFF, 32'sh0);
    a_mem = '{32'sh0000_0000, 32'shFFFF_0000, 32'sh0001_0000, 32'sh0000_4000};
    exp_p = '{16'h8000, 16'h1E84, 16'hE17C, 16'h9D93};
    run(1'b1, 1'b0, 0);

    // Diagonal weights with only h[0] set: only visible 0 sees a term.
    fill(16'h0000, 16'sh0000, 32'sh0);
    bus.h_mem = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < V; i++) w_mem[i*H + i] = 16'sh4000;
    exp_p = '{16'h9D8B, 16'h8000, 16'h8000, 16'h8000};
    run(1'b1, 1'b0, 0);

    // Saturation: rows 0-1 positive extreme, rows 2-3 negative extreme.
    fill(16'hFFFF, 16'sh7FFF, 32'sh7FFF_0000);
    for (int n = 2*H; n < V*H; n++) w_mem[n] = 16'sh8000;
    a_mem[2] = 32'sh8001_0000;
    a_mem[3] = 32'sh8001_0000;
    exp_p = '{16'hFFEA, 16'hFFEA, 16'h0016, 16'h0016};
    run(1'b1, 1'b0, 0);

    // Back-pressure at idx 0 for 10 cycles.
    fill(16'h0000, 16'sh7FFF, 32'sh0);
    a_mem = '{32'sh0000_0000, 32'shFFFF_0000, 32'sh0001_0000, 32'sh0000_4000};
    exp_p = '{16'h8000, 16'h1E84, 16'hE17C, 16'h9D93};
    run(1'b0, 1'b0, 10);

    // Reset in the middle of ACC aborts without done.
    bus.p_ready = 1'b1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {bus.busy, bus.p_valid, bus.done}, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_%0d", c), {bus.busy, bus.p_valid, bus.done}, 0);
    end

    // Fresh run reproduces the all-zero result.
    fill(16'h0000, 16'sh1234, 32'sh0);
    exp_p = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    run(1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
